spi_xfer_ctrl: RTL

SPI master transfer controller: accepts one DATA_W-bit word over a valid/ready handshake and sequences a complete SPI transaction on the pins. The transaction runs from chip-select assertion, through 2·DATA_W serial clock edges, to a chip-select gap. The serial clock comes from an internal programmable tick divider, so it replaces the fixed-ratio slow-clock divider and keeps the whole SPI path in the single system clock domain. It sits between the host-side command logic and the SPI pads.

---
 rtl/spi_pkg.sv | 9 +
 rtl/spi_tick_gen.sv | 18 +
 rtl/spi_xfer_ctrl.sv | 110 +++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
// spi_pkg: shared FSM state, SPI mode type and default mode for the SPI transfer controller.
package spi_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
  typedef struct packed {
    logic cpol;
    logic cpha;
  } mode_t;
  localparam mode_t MODE0 = 2'b00;
endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: programmable divider emitting a one-cycle tick every div+1 enabled cycles.
module spi_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt_q;
  assign tick = en && cnt_q == div;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else if (clr) cnt_q <= '0;
    else if (en) cnt_q <= tick ? '0 : cnt_q + 1'b1;
endmodule

// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: SPI master sequencing one DATA_W-bit word per valid/ready handshake.
// Build option: define SPI_MODE_CFG_EN to add cpol/cpha ports (all four modes); otherwise fixed mode 0.
module spi_xfer_ctrl
  import spi_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  div,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [DATA_W-1:0] tx_data,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
`ifdef SPI_MODE_CFG_EN
  input  logic              cpol,
  input  logic              cpha,
`endif
  output logic              cs_n
);
  localparam int EW = $clog2(2 * DATA_W);
  localparam logic [EW-1:0] E_LAST = EW'(2 * DATA_W - 1);
  state_t            state_q;
  mode_t             mode_q, mode_d;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] tx_q, rx_q, rx_data_q;
  logic [EW-1:0]     e_q;
  logic              sclk_q, mosi_q, cs_n_q, rx_valid_q;
  logic              tick, accept, do_shift, do_sample;
`ifdef SPI_MODE_CFG_EN
  assign mode_d = {cpol, cpha};
`else
  assign mode_d = MODE0;
`endif
  assign tx_ready = state_q == IDLE;
  assign busy     = !tx_ready;
  assign accept   = tx_valid && tx_ready;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign cs_n     = cs_n_q;
  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  // Odd edge is the trailing edge; with cpha=0 the last trailing edge has no bit left to drive.
  assign do_shift  = mode_q.cpha ? !e_q[0] : (e_q[0] && e_q != E_LAST);
  assign do_sample = mode_q.cpha ? e_q[0] : !e_q[0];
  spi_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (busy),
    .div  (div_q),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q    <= IDLE;
      mode_q     <= MODE0;
      div_q      <= '0;
      tx_q       <= '0;
      rx_q       <= '0;
      rx_data_q  <= '0;
      e_q        <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      rx_valid_q <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sclk_q <= mode_d.cpol;
          if (tx_valid) begin
            state_q <= LEAD;
            mode_q  <= mode_d;
            div_q   <= div;
            e_q     <= '0;
            cs_n_q  <= 1'b0;
            tx_q    <= mode_d.cpha ? tx_data : tx_data << 1;
            if (!mode_d.cpha) mosi_q <= tx_data[DATA_W-1];
          end
        end
        LEAD: if (tick) state_q <= SHIFT;
        SHIFT: if (tick) begin
          sclk_q <= !sclk_q;
          e_q    <= e_q == E_LAST ? '0 : e_q + 1'b1;
          if (e_q == E_LAST) state_q <= TRAIL;
          if (do_shift) begin
            mosi_q <= tx_q[DATA_W-1];
            tx_q   <= tx_q << 1;
          end
          if (do_sample) rx_q <= {rx_q[DATA_W-2:0], miso};
        end
        TRAIL: if (tick) begin
          state_q    <= GAP;
          sclk_q     <= mode_q.cpol;
          cs_n_q     <= 1'b1;
          rx_data_q  <= rx_q;
          rx_valid_q <= 1'b1;
        end
        GAP: if (tick) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
endmodule
